// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters,
// launches operands from registers and holds each response until it is consumed.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int RR_INIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [1:0]       req0_ctrl_i,
  input  logic             req0_s_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [1:0]       req1_ctrl_i,
  input  logic             req1_s_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [1:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [3:0]       alu_nzcv_i,
  output logic [3:0]       flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             prio_q;
  logic             op_s_q;
  logic             op_id_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_ctrl_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [3:0]       flags_q;

  logic gnt_valid;
  logic gnt_id;

  // Priority only matters on contention; a lone requester always wins.
  assign gnt_valid = req0_valid_i | req1_valid_i;
  assign gnt_id    = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;

  assign req0_ready_o = (state_q == IDLE) && gnt_valid && !gnt_id;
  assign req1_ready_o = (state_q == IDLE) && gnt_valid &&  gnt_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      prio_q       <= (RR_INIT != 0);
      op_s_q       <= 1'b0;
      op_id_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            alu_a_q    <= gnt_id ? req1_a_i    : req0_a_i;
            alu_b_q    <= gnt_id ? req1_b_i    : req0_b_i;
            alu_ctrl_q <= gnt_id ? req1_ctrl_i : req0_ctrl_i;
            op_s_q     <= gnt_id ? req1_s_i    : req0_s_i;
            op_id_q    <= gnt_id;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result_i;
          rsp_flags_q  <= alu_nzcv_i;
          rsp_id_q     <= op_id_q;
          if (op_s_q) flags_q <= alu_nzcv_i;
          prio_q       <= ~op_id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign flags_o      = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural stand-in for the shared ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_s;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_ctrl;
  logic        req1_valid, req1_ready, req1_s;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_nzcv;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .RR_INIT(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
    .req0_b_i(req0_b), .req0_ctrl_i(req0_ctrl), .req0_s_i(req0_s),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
    .req1_b_i(req1_b), .req1_ctrl_i(req1_ctrl), .req1_s_i(req1_s),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_result), .alu_nzcv_i(alu_nzcv), .flags_o(flags)
  );

  // ARM-style flags: C is carry-out on ADD and not-borrow on SUB; logic ops clear C and V.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_nzcv   = '0;
    case (alu_ctrl)
      2'b00: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[31:0];
        alu_nzcv   = {alu_result[31], alu_result == 32'd0, alu_sum[32],
                      (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31])};
      end
      2'b01: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = alu_sum[31:0];
        alu_nzcv   = {alu_result[31], alu_result == 32'd0, alu_sum[32],
                      (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31])};
      end
      2'b10: begin
        alu_result = alu_a & alu_b;
        alu_nzcv   = {alu_result[31], alu_result == 32'd0, 2'b00};
      end
      default: begin
        alu_result = alu_a | alu_b;
        alu_nzcv   = {alu_result[31], alu_result == 32'd0, 2'b00};
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 ns after a rising edge with the DUT idle and rsp_ready high.
  task automatic run_single(input string tag, input bit id, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] ctrl, input bit s,
                            input logic [31:0] exp_res, input logic [3:0] exp_fl,
                            input logic [3:0] exp_arch);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_s = s;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_s = s;
    end
    #1;
    check({tag, ".ready"},   32'(id ? req1_ready : req0_ready), 32'd1);
    check({tag, ".ready_n"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, ".exec_vld"}, 32'(rsp_valid), 32'd0);
    check({tag, ".alu_a"},    alu_a, a);
    check({tag, ".alu_b"},    alu_b, b);
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(ctrl));
    tick();
    check({tag, ".rsp_vld"},  32'(rsp_valid), 32'd1);
    check({tag, ".result"},   rsp_result, exp_res);
    check({tag, ".rsp_fl"},   32'(rsp_flags), 32'(exp_fl));
    check({tag, ".rsp_id"},   32'(rsp_id), 32'(id));
    check({tag, ".flags"},    32'(flags), 32'(exp_arch));
    tick();
    check({tag, ".vld_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_s = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_s = 1'b0;
    tick();
    tick();
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_id",    32'(rsp_id), 32'd0);
    check("rst.result",    rsp_result, 32'd0);
    check("rst.rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst.flags",     32'(flags), 32'd0);
    check("rst.alu_a",     alu_a, 32'd0);
    check("rst.ready0",    32'(req0_ready), 32'd0);
    check("rst.ready1",    32'(req1_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("idle.ready0", 32'(req0_ready), 32'd0);
    check("idle.ready1", 32'(req1_ready), 32'd0);

    run_single("add", 1'b0, 32'd10, 32'd5, 2'b00, 1'b1, 32'd15, 4'b0000, 4'b0000);
    run_single("sub", 1'b0, 32'd5, 32'd10, 2'b01, 1'b1, 32'hFFFF_FFFB, 4'b1000, 4'b1000);
    run_single("ovf", 1'b1, 32'd2000000000, 32'd2000000000, 2'b00, 1'b0,
               32'hEE6B_2800, 4'b1001, 4'b1000);

    // Contention: last grant was to requester 1, so alternation starts at 0.
    req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0F0F_0F0F; req0_ctrl = 2'b10; req0_s = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hF0F0_F0F0; req1_b = 32'h0F0F_0F0F; req1_ctrl = 2'b11; req1_s = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d.ready0", k), 32'(req0_ready), 32'(k % 2 == 0));
      check($sformatf("rr%0d.ready1", k), 32'(req1_ready), 32'(k % 2 == 1));
      tick();
      tick();
      check($sformatf("rr%0d.rsp_id", k), 32'(rsp_id), 32'(k % 2));
      check($sformatf("rr%0d.result", k), rsp_result, (k % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF);
      check($sformatf("rr%0d.rsp_fl", k), 32'(rsp_flags), (k % 2 == 0) ? 32'h4 : 32'h8);
      check($sformatf("rr%0d.flags", k),  32'(flags), 32'h8);
      tick();
    end

    // Back-pressure: response held for 10 cycles with both still requesting.
    rsp_ready = 1'b0;
    check("bp.grant0", 32'(req0_ready), 32'd1);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d.valid", k),  32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d.id", k),     32'(rsp_id), 32'd0);
      check($sformatf("bp%0d.result", k), rsp_result, 32'd0);
      check($sformatf("bp%0d.fl", k),     32'(rsp_flags), 32'h4);
      check($sformatf("bp%0d.ready0", k), 32'(req0_ready), 32'd0);
      check($sformatf("bp%0d.ready1", k), 32'(req1_ready), 32'd0);
      check($sformatf("bp%0d.alu_ctrl", k), 32'(alu_ctrl), 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp.vld_drop", 32'(rsp_valid), 32'd0);
    check("bp.ready0",   32'(req0_ready), 32'd0);
    check("bp.ready1",   32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("bp.next_id",  32'(rsp_id), 32'd1);
    check("bp.next_res", rsp_result, 32'hFFFF_FFFF);
    tick();

    // Wrap to zero: carry and zero both set, leaves priority with requester 1.
    run_single("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1, 32'd0, 4'b0110, 4'b0110);

    // Reset while an S-bit op is executing.
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd10; req1_ctrl = 2'b01; req1_s = 1'b1;
    #1;
    check("rx.ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rx.valid",  32'(rsp_valid), 32'd0);
    check("rx.flags",  32'(flags), 32'd0);
    check("rx.alu_a",  alu_a, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rx%0d.valid", k), 32'(rsp_valid), 32'd0);
      check($sformatf("rx%0d.flags", k), 32'(flags), 32'd0);
    end
    req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0F0F_0F0F; req0_ctrl = 2'b10; req0_s = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hF0F0_F0F0; req1_b = 32'h0F0F_0F0F; req1_ctrl = 2'b11; req1_s = 1'b0;
    #1;
    check("rx.prio0", 32'(req0_ready), 32'd1);
    check("rx.prio1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("rx.rsp_id", 32'(rsp_id), 32'd0);
    check("rx.result", rsp_result, 32'd0);
    check("rx.rsp_fl", 32'(rsp_flags), 32'h4);
    check("rx.flags2", 32'(flags), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
